// File: rtl/card_display_pkg.sv
// Shared types and constants for the card draw and seven-segment display slice.
// Segment vectors are active low, bit order {g,f,e,d,c,b,a}.
package card_display_pkg;

    typedef logic [6:0] seg_t;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
    } dec_digits_t;

    localparam int CARD_MAX_DEFAULT  = 13;
    localparam int COUNT_MAX_DEFAULT = 4;

    localparam seg_t SEG_0     = 7'b1000000;
    localparam seg_t SEG_1     = 7'b1111001;
    localparam seg_t SEG_2     = 7'b0100100;
    localparam seg_t SEG_3     = 7'b0110000;
    localparam seg_t SEG_4     = 7'b0011001;
    localparam seg_t SEG_5     = 7'b0010010;
    localparam seg_t SEG_6     = 7'b0000010;
    localparam seg_t SEG_7     = 7'b1111000;
    localparam seg_t SEG_8     = 7'b0000000;
    localparam seg_t SEG_9     = 7'b0010000;
    localparam seg_t SEG_A     = 7'b0001000;
    localparam seg_t SEG_B     = 7'b0000011;
    localparam seg_t SEG_C     = 7'b1000110;
    localparam seg_t SEG_D     = 7'b0100001;
    localparam seg_t SEG_E     = 7'b0000110;
    localparam seg_t SEG_F     = 7'b0001110;
    localparam seg_t SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_hex_decoder.sv
// Hex nibble to active-low seven-segment pattern ({g,f,e,d,c,b,a}).
module seg7_hex_decoder
    import card_display_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (value)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
        endcase
    end

endmodule

// File: rtl/card_draw_display.sv
// Free-running card/count sources sampled by a draw press, plus HEX display formatting.
// Optional macro CARD_LEADING_BLANK_EN blanks tens digits for values below 10.
module card_draw_display
    import card_display_pkg::*;
#(
    parameter int CARD_MAX  = CARD_MAX_DEFAULT,
    parameter int COUNT_MAX = COUNT_MAX_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       draw,
    input  logic       mode,
    input  logic [5:0] score,
    input  logic [3:0] glyph,
    output logic [3:0] card,
    output logic [6:0] card_tens,
    output logic [6:0] card_ones,
    output logic [6:0] score_tens,
    output logic [6:0] score_ones,
    output logic [6:0] glyph_seg
);

    logic [3:0]  card_cnt;
    logic [3:0]  count_cnt;
    logic        draw_q;
    logic        draw_edge;
    dec_digits_t card_digits;
    dec_digits_t score_digits;
    logic [6:0]  card_tens_raw;
    logic [6:0]  score_tens_raw;

    // Repeated subtraction keeps the 0..63 split small and fully combinational.
    function automatic dec_digits_t split_decimal(input logic [5:0] value);
        dec_digits_t digits;
        logic [5:0]  rest;
        rest        = value;
        digits.tens = 4'd0;
        for (int i = 0; i < 6; i++) begin
            if (rest >= 6'd10) begin
                rest        = rest - 6'd10;
                digits.tens = digits.tens + 4'd1;
            end
        end
        digits.ones = 4'(rest);
        return digits;
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            card_cnt  <= 4'd1;
            count_cnt <= 4'd1;
        end else begin
            card_cnt  <= (card_cnt == 4'(CARD_MAX)) ? 4'd1 : card_cnt + 4'd1;
            count_cnt <= (count_cnt == 4'(COUNT_MAX)) ? 4'd1 : count_cnt + 4'd1;
        end
    end

    assign draw_edge = draw & ~draw_q;

    // Reset clears draw_q, so a key still held through reset fires once afterwards.
    always_ff @(posedge clock) begin
        if (reset) begin
            draw_q <= 1'b0;
            card   <= 4'd0;
        end else begin
            draw_q <= draw;
            if (draw_edge) begin
                card <= mode ? count_cnt : card_cnt;
            end
        end
    end

    assign card_digits  = split_decimal({2'b00, card});
    assign score_digits = split_decimal(score);

    seg7_hex_decoder u_card_tens  (.value(card_digits.tens),  .seg(card_tens_raw));
    seg7_hex_decoder u_card_ones  (.value(card_digits.ones),  .seg(card_ones));
    seg7_hex_decoder u_score_tens (.value(score_digits.tens), .seg(score_tens_raw));
    seg7_hex_decoder u_score_ones (.value(score_digits.ones), .seg(score_ones));
    seg7_hex_decoder u_glyph      (.value(glyph),             .seg(glyph_seg));

`ifdef CARD_LEADING_BLANK_EN
    assign card_tens  = (card_digits.tens == 4'd0)  ? SEG_BLANK : card_tens_raw;
    assign score_tens = (score_digits.tens == 4'd0) ? SEG_BLANK : score_tens_raw;
`else
    assign card_tens  = card_tens_raw;
    assign score_tens = score_tens_raw;
`endif

endmodule

// File: tb/tb_card_draw_display.sv
// Scoreboard bench for card_draw_display: stimulus queues expectations, a negedge monitor checks them.
module tb_card_draw_display;

    typedef enum logic [2:0] {
        SIG_CARD,
        SIG_CARD_TENS,
        SIG_CARD_ONES,
        SIG_SCORE_TENS,
        SIG_SCORE_ONES,
        SIG_GLYPH
    } sig_e;

    typedef struct {
        int         due;
        sig_e       sig;
        logic [6:0] value;
        string      name;
    } exp_t;

`ifdef CARD_LEADING_BLANK_EN
    localparam logic [6:0] TENS_ZERO = 7'b1111111;
`else
    localparam logic [6:0] TENS_ZERO = 7'b1000000;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       draw  = 1'b0;
    logic       mode  = 1'b0;
    logic [5:0] score = 6'd0;
    logic [3:0] glyph = 4'd0;
    logic [3:0] card;
    logic [6:0] card_tens;
    logic [6:0] card_ones;
    logic [6:0] score_tens;
    logic [6:0] score_ones;
    logic [6:0] glyph_seg;

    int   cycle = 0;
    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];

    card_draw_display dut (
        .clock      (clock),
        .reset      (reset),
        .draw       (draw),
        .mode       (mode),
        .score      (score),
        .glyph      (glyph),
        .card       (card),
        .card_tens  (card_tens),
        .card_ones  (card_ones),
        .score_tens (score_tens),
        .score_ones (score_ones),
        .glyph_seg  (glyph_seg)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cycle <= cycle + 1;

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input string name, input sig_e sig, input logic [6:0] value,
                                 input int delay);
        exp_t e;
        e.due   = cycle + delay;
        e.sig   = sig;
        e.value = value;
        e.name  = name;
        exp_q.push_back(e);
    endtask

    // One isolated press: the edge cycle samples the counter value of the current cycle.
    task automatic pulse(input string name, input logic m, input logic [3:0] exp_card,
                         input logic [6:0] exp_tens, input logic [6:0] exp_ones);
        draw = 1'b1;
        mode = m;
        step(1);
        applyStimulus({name, "_card"}, SIG_CARD, {3'b000, exp_card}, 0);
        applyStimulus({name, "_tens"}, SIG_CARD_TENS, exp_tens, 0);
        applyStimulus({name, "_ones"}, SIG_CARD_ONES, exp_ones, 0);
        draw = 1'b0;
        step(1);
    endtask

    task automatic checkOutput(input exp_t e);
        logic [6:0] actual;
        case (e.sig)
            SIG_CARD:       actual = {3'b000, card};
            SIG_CARD_TENS:  actual = card_tens;
            SIG_CARD_ONES:  actual = card_ones;
            SIG_SCORE_TENS: actual = score_tens;
            SIG_SCORE_ONES: actual = score_ones;
            default:        actual = glyph_seg;
        endcase
        total++;
        if (actual !== e.value) begin
            bad++;
            $display("[TB] FAIL %s at cycle %0d: got %b expected %b", e.name, cycle, actual, e.value);
        end
    endtask

    initial begin
        forever begin
            @(negedge clock);
            while (exp_q.size() > 0 && exp_q[0].due <= cycle) begin
                checkOutput(exp_q.pop_front());
            end
        end
    end

    initial begin
        // Reset held for two cycles; counters restart at 1 on the second edge.
        step(2);
        applyStimulus("reset_card", SIG_CARD, 7'd0, 0);
        applyStimulus("reset_ones", SIG_CARD_ONES, 7'b1000000, 0);
        applyStimulus("reset_tens", SIG_CARD_TENS, TENS_ZERO, 0);
        reset = 1'b0;

        step(4);
        draw = 1'b1;
        mode = 1'b0;
        step(1);
        applyStimulus("sample5_card", SIG_CARD, 7'd5, 0);
        applyStimulus("sample5_ones", SIG_CARD_ONES, 7'b0010010, 0);
        applyStimulus("sample5_tens", SIG_CARD_TENS, TENS_ZERO, 0);
        mode = 1'b1;
        step(20);
        applyStimulus("hold_card", SIG_CARD, 7'd5, 0);
        draw = 1'b0;
        step(2);

        pulse("count4a", 1'b1, 4'd4,  TENS_ZERO,  7'b0011001);
        pulse("count2",  1'b1, 4'd2,  TENS_ZERO,  7'b0100100);
        pulse("count4b", 1'b1, 4'd4,  TENS_ZERO,  7'b0011001);
        pulse("card8",   1'b0, 4'd8,  TENS_ZERO,  7'b0000000);
        pulse("card10",  1'b0, 4'd10, 7'b1111001, 7'b1000000);
        pulse("card12",  1'b0, 4'd12, 7'b1111001, 7'b0100100);
        pulse("card1",   1'b0, 4'd1,  TENS_ZERO,  7'b1111001);
        pulse("card3",   1'b0, 4'd3,  TENS_ZERO,  7'b0110000);
        step(8);
        pulse("card13",  1'b0, 4'd13, 7'b1111001, 7'b0110000);
        pulse("card2",   1'b0, 4'd2,  TENS_ZERO,  7'b0100100);

        score = 6'd21;
        glyph = 4'hA;
        applyStimulus("score21_tens", SIG_SCORE_TENS, 7'b0100100, 0);
        applyStimulus("score21_ones", SIG_SCORE_ONES, 7'b1111001, 0);
        applyStimulus("glyph_A", SIG_GLYPH, 7'b0001000, 0);
        step(1);
        score = 6'd63;
        glyph = 4'hD;
        applyStimulus("score63_tens", SIG_SCORE_TENS, 7'b0000010, 0);
        applyStimulus("score63_ones", SIG_SCORE_ONES, 7'b0110000, 0);
        applyStimulus("glyph_d", SIG_GLYPH, 7'b0100001, 0);
        step(1);
        score = 6'd7;
        glyph = 4'hE;
        applyStimulus("score7_tens", SIG_SCORE_TENS, TENS_ZERO, 0);
        applyStimulus("score7_ones", SIG_SCORE_ONES, 7'b1111000, 0);
        applyStimulus("glyph_E", SIG_GLYPH, 7'b0000110, 0);
        step(1);
        score = 6'd10;
        glyph = 4'hF;
        applyStimulus("score10_tens", SIG_SCORE_TENS, 7'b1111001, 0);
        applyStimulus("score10_ones", SIG_SCORE_ONES, 7'b1000000, 0);
        applyStimulus("glyph_F", SIG_GLYPH, 7'b0001110, 0);
        step(1);

        // Press held across reset: one load of 1 right after release, then nothing until re-press.
        draw  = 1'b1;
        mode  = 1'b0;
        reset = 1'b1;
        step(2);
        applyStimulus("rstpress_card0", SIG_CARD, 7'd0, 0);
        reset = 1'b0;
        step(1);
        applyStimulus("rstpress_card1", SIG_CARD, 7'd1, 0);
        applyStimulus("rstpress_ones1", SIG_CARD_ONES, 7'b1111001, 0);
        step(5);
        applyStimulus("rstpress_hold", SIG_CARD, 7'd1, 0);
        draw = 1'b0;
        step(1);
        draw = 1'b1;
        step(1);
        applyStimulus("repress_card8", SIG_CARD, 7'd8, 0);
        applyStimulus("repress_ones8", SIG_CARD_ONES, 7'b0000000, 0);
        draw = 1'b0;

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            @(posedge clock);
        end
        if (exp_q.size() > 0) begin
            $display("[TB] FAIL drain: got %0d pending checks expected 0", exp_q.size());
            total += exp_q.size();
            bad   += exp_q.size();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
